// File: rtl/clk_gen_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_gen_div_pkg;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam int unsigned MIN_DIV = 2;

   // Ratios below MIN_DIV cannot form a high and a low phase, so they are raised to MIN_DIV.
   function automatic int unsigned clamp_div(input int unsigned d);
      return (d < MIN_DIV) ? MIN_DIV : d;
   endfunction

endpackage

// File: rtl/clk_gen_div_if.sv
// Control/status bundle of clk_gen_div; CLK_GEN_DIV_STROBE_EN adds rise_o/fall_o edge strobes.
interface clk_gen_div_if #(
   parameter int DIV_WIDTH = 16
) ();
   logic                 en_i;
   logic [DIV_WIDTH-1:0] div_i;
   logic                 div_valid_i;
   logic                 div_ready_o;
   logic                 clk_o;
   logic                 busy_o;
`ifdef CLK_GEN_DIV_STROBE_EN
   logic                 rise_o;
   logic                 fall_o;
`endif

   modport master (
      output en_i, div_i, div_valid_i,
`ifdef CLK_GEN_DIV_STROBE_EN
      input  rise_o, fall_o,
`endif
      input  div_ready_o, clk_o, busy_o
   );

   modport slave (
      input  en_i, div_i, div_valid_i,
`ifdef CLK_GEN_DIV_STROBE_EN
      output rise_o, fall_o,
`endif
      output div_ready_o, clk_o, busy_o
   );
endinterface

// File: rtl/clk_gen_div_cnt.sv
// Period counter next-state and high-phase compare; the count register lives in the top.
module clk_gen_div_cnt #(
   parameter int DIV_WIDTH = 16
) (
   input  logic [DIV_WIDTH-1:0] cnt,
   input  logic [DIV_WIDTH-1:0] div_q,
   output logic                 clk_next,
   output logic                 boundary,
   output logic [DIV_WIDTH-1:0] cnt_next
);
   localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

   logic [DIV_WIDTH-1:0] high_len;

   // Ceiling half: odd ratios spend the extra cycle high.
   assign high_len = div_q - (div_q >> 1);
   assign boundary = (cnt == div_q - ONE);
   assign cnt_next = boundary ? '0 : cnt + ONE;
   assign clk_next = (cnt < high_len);
endmodule

// File: rtl/clk_gen_div.sv
// Glitch-free programmable clock divider; define CLK_GEN_DIV_STROBE_EN for rise_o/fall_o strobes.
module clk_gen_div
   import clk_gen_div_pkg::*;
#(
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   clk_gen_div_if.slave bus
);
   localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(clamp_div(DEFAULT_DIV));

   state_t               state;
   logic [DIV_WIDTH-1:0] cnt, cnt_next, div_q, div_pend, div_in;
   logic                 pending, clk_q, busy_q;
   logic                 clk_next, boundary, at_bnd, xfer, clk_d;

   clk_gen_div_cnt #(.DIV_WIDTH(DIV_WIDTH)) u_cnt (
      .cnt      (cnt),
      .div_q    (div_q),
      .clk_next (clk_next),
      .boundary (boundary),
      .cnt_next (cnt_next)
   );

   assign div_in = DIV_WIDTH'(clamp_div(32'(bus.div_i)));
   assign xfer   = bus.div_valid_i & ~pending;
   assign at_bnd = (state == RUN) & boundary;
   assign clk_d  = (state == RUN) & clk_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         div_q    <= DIV_RST;
         div_pend <= '0;
         pending  <= 1'b0;
         clk_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         // A ratio only takes effect where cnt restarts at 0, so clk_o never sees a runt phase.
         if (xfer && (state == IDLE || at_bnd)) begin
            div_q <= div_in;
         end else if (xfer) begin
            div_pend <= div_in;
            pending  <= 1'b1;
         end else if (at_bnd && pending) begin
            div_q   <= div_pend;
            pending <= 1'b0;
         end
         clk_q <= clk_d;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (bus.en_i) begin
                  state  <= RUN;
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               cnt <= cnt_next;
               if (at_bnd && !bus.en_i) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.clk_o       = clk_q;
   assign bus.busy_o      = busy_q;
   assign bus.div_ready_o = ~pending;

`ifdef CLK_GEN_DIV_STROBE_EN
   logic rise_q, fall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= clk_d & ~clk_q;
         fall_q <= ~clk_d & clk_q;
      end
   end

   assign bus.rise_o = rise_q;
   assign bus.fall_o = fall_q;
`endif
endmodule

// File: tb/tb_clk_gen_div.sv
// Self-checking bench for clk_gen_div: vector table plus hand sequences feeding a cycle-tagged scoreboard.
module tb_clk_gen_div;

   typedef struct {
      int    cyc;
      logic  clk;
      logic  busy;
      logic  rdy;
      logic  rise;
      logic  fall;
      string name;
   } exp_t;

   typedef struct {
      logic [15:0] div;
      int          ratio;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cycle = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   logic prev_clk = 1'b0;
   exp_t sb[$];
   vec_t vecs[6];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   clk_gen_div_if #(.DIV_WIDTH(16)) bus ();

   clk_gen_div #(.DIV_WIDTH(16), .DEFAULT_DIV(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Drive one cycle of inputs and queue what the outputs must be after the next edge.
   task automatic drive(input logic r, input logic e, input logic v, input logic [15:0] d,
                        input logic c_exp, input logic b_exp, input logic rd_exp, input string nm);
      exp_t x;
      rst             = r;
      bus.en_i        = e;
      bus.div_valid_i = v;
      bus.div_i       = d;
      x.cyc  = cycle + 1;
      x.clk  = c_exp;
      x.busy = b_exp;
      x.rdy  = rd_exp;
      x.rise = r ? 1'b0 : (c_exp & ~prev_clk);
      x.fall = r ? 1'b0 : (~c_exp & prev_clk);
      x.name = nm;
      prev_clk = c_exp;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   // One full period of the given ratio starting at cnt=0.
   task automatic period(input int ratio, input logic en_end, input logic en_mid, input string nm);
      int h;
      h = ratio - ratio / 2;
      for (int i = 0; i < ratio; i++)
         drive(1'b0, (i == ratio - 1) ? en_end : en_mid, 1'b0, 16'h0,
               (i < h), (en_end || i != ratio - 1), 1'b1, nm);
   endtask

   always begin
      @(posedge clk);
      #2;
      while (sb.size() > 0 && sb[0].cyc == cycle) begin
         exp_t x;
         logic ok;
         x  = sb.pop_front();
         ok = (bus.clk_o === x.clk) && (bus.busy_o === x.busy) && (bus.div_ready_o === x.rdy);
`ifdef CLK_GEN_DIV_STROBE_EN
         ok = ok && (bus.rise_o === x.rise) && (bus.fall_o === x.fall);
`endif
         n_tests++;
         if (!ok) begin
            n_fail++;
`ifdef CLK_GEN_DIV_STROBE_EN
            $display("FAIL %s cyc %0d: clk/busy/rdy/rise/fall got %b%b%b%b%b want %b%b%b%b%b",
                     x.name, x.cyc, bus.clk_o, bus.busy_o, bus.div_ready_o, bus.rise_o, bus.fall_o,
                     x.clk, x.busy, x.rdy, x.rise, x.fall);
`else
            $display("FAIL %s cyc %0d: clk/busy/rdy got %b%b%b want %b%b%b",
                     x.name, x.cyc, bus.clk_o, bus.busy_o, bus.div_ready_o, x.clk, x.busy, x.rdy);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete, %0d expectations pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{div: 16'd5, ratio: 5};
      vecs[1] = '{div: 16'd0, ratio: 2};
      vecs[2] = '{div: 16'd1, ratio: 2};
      vecs[3] = '{div: 16'd3, ratio: 3};
      vecs[4] = '{div: 16'd7, ratio: 7};
      vecs[5] = '{div: 16'd2, ratio: 2};
      bus.en_i        = 1'b0;
      bus.div_valid_i = 1'b0;
      bus.div_i       = 16'h0;

      // reset and default ratio 4
      drive(1, 0, 0, 0, 0, 0, 1, "reset");
      drive(1, 0, 0, 0, 0, 0, 1, "reset_hold");
      drive(0, 1, 0, 0, 0, 1, 1, "run_entry");
      period(4, 1, 1, "div4_p1");
      period(4, 1, 1, "div4_p2");
      // en dropped at cnt=1: the period still completes
      drive(0, 1, 0, 0, 1, 1, 1, "drop_c0");
      drive(0, 0, 0, 0, 1, 1, 1, "drop_c1");
      drive(0, 0, 0, 0, 0, 1, 1, "drop_c2");
      drive(0, 0, 0, 0, 0, 0, 1, "drop_c3");
      drive(0, 0, 0, 0, 0, 0, 1, "idle");

      foreach (vecs[k]) begin
         drive(0, 0, 1, vecs[k].div, 0, 0, 1, $sformatf("v%0d_idle_load", k));
         drive(0, 1, 0, 0, 0, 1, 1, $sformatf("v%0d_entry", k));
         period(vecs[k].ratio, 1, 1, $sformatf("v%0d_run", k));
         period(vecs[k].ratio, 1, 0, $sformatf("v%0d_en_glitch", k));
         period(vecs[k].ratio, 0, 1, $sformatf("v%0d_stop", k));
         drive(0, 0, 0, 0, 0, 0, 1, $sformatf("v%0d_idle", k));
      end

      // mid-period update 4 -> 6, held-off write of 9, boundary write of 3
      drive(0, 0, 1, 4, 0, 0, 1, "u_ld4");
      drive(0, 1, 0, 0, 0, 1, 1, "u_entry");
      drive(0, 1, 0, 0, 1, 1, 1, "u_c0");
      drive(0, 1, 1, 6, 1, 1, 0, "u_c1_wr6");
      drive(0, 1, 1, 9, 0, 1, 0, "u_c2_hold9");
      drive(0, 1, 0, 0, 0, 1, 1, "u_c3_bnd");
      for (int i = 0; i < 6; i++)
         drive(0, 1, (i == 5), 3, (i < 3), 1, 1, "u_div6");
      period(3, 1, 1, "u_div3");
      period(3, 0, 1, "u_div3_stop");

      // reset during high phase drops the pending ratio
      drive(0, 1, 0, 0, 0, 1, 1, "r_entry");
      drive(0, 1, 0, 0, 1, 1, 1, "r_c0");
      drive(0, 1, 1, 8, 1, 1, 0, "r_c1_wr8");
      drive(1, 1, 0, 0, 0, 0, 1, "r_mid_reset");
      drive(0, 1, 0, 0, 0, 1, 1, "r_reentry");
      period(4, 1, 1, "r_default4");
      period(4, 0, 1, "r_stop");

      repeat (2) @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
